// File: rtl/rf_mixer_nco_iq.sv
// Quadrature 1-bit RF downconverter: RF synchroniser, phase-accumulator NCO with
// phase-continuous retune handshake, cos/-sin LO LUT and registered I/Q mixer.
// Optional LFSR phase dither before LUT addressing: define RF_MIXER_NCO_IQ_DITHER_EN.
module rf_mixer_nco_iq #(
  parameter int                 PHASE_W     = 16,
  parameter int                 LUT_AW      = 4,
  parameter int                 OUT_W       = 4,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [PHASE_W-1:0] RESET_INC   = '0
) (
  input  logic                     clk,
  input  logic                     RSTb,
  input  logic                     rf_in,
  output logic                     rf_out,
  input  logic [PHASE_W-1:0]       inc_data,
  input  logic                     inc_load,
  output logic                     inc_busy,
  input  logic                     phase_clr,
  output logic signed [OUT_W-1:0]  i_out,
  output logic signed [OUT_W-1:0]  q_out,
  output logic signed [OUT_W-1:0]  lo_i,
  output logic signed [OUT_W-1:0]  lo_q,
  output logic                     out_valid
);

  localparam int  N   = 1 << LUT_AW;
  localparam int  AMP = (1 << (OUT_W - 1)) - 1;
  localparam real PI  = 3.14159265358979323846;
  localparam logic [LUT_AW-1:0] QTR = LUT_AW'(N / 4);

  if (LUT_AW < 2 || LUT_AW >= PHASE_W || SYNC_STAGES < 2) begin : g_bad_cfg
    $error("rf_mixer_nco_iq: illegal LUT_AW / PHASE_W / SYNC_STAGES combination");
  end

  // Taylor series, accurate far beyond OUT_W rounding on [0, pi/2].
  function automatic real cos_poly(input real x);
    real term;
    real acc;
    acc  = 1.0;
    term = 1.0;
    for (int n = 1; n <= 10; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic logic signed [OUT_W-1:0] lut_entry(input int k);
    int  quad;
    int  rem;
    int  r;
    real x;
    real c;
    real scaled;
    quad = k / (N / 4);
    rem  = k % (N / 4);
    x    = 2.0 * PI * real'(rem) / real'(N);
    case (quad)
      0:       c =  cos_poly(x);
      1:       c = -cos_poly(PI / 2.0 - x);
      2:       c = -cos_poly(x);
      default: c =  cos_poly(PI / 2.0 - x);
    endcase
    scaled = real'(AMP) * c;
    if (scaled >= 0.0) r =  $rtoi(scaled + 0.5);
    else               r = -$rtoi(0.5 - scaled);
    return OUT_W'(r);
  endfunction

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic [PHASE_W-1:0]       active_inc_q, active_inc_d;
  logic [PHASE_W-1:0]       pending_inc_q, pending_inc_d;
  logic [PHASE_W:0]         sum;
  logic                     wrap;
  logic                     rf_sync;
  logic [LUT_AW-1:0]        addr_cos;
  logic [LUT_AW-1:0]        addr_msin;
  logic signed [OUT_W-1:0]  lo_cos, lo_msin;
  logic signed [OUT_W-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;
  logic signed [OUT_W-1:0]  lo_i_q, lo_q_q;
  logic                     valid_pre_q, out_valid_q;

  // NOTE: the table is a constant, so it has no reset and no storage.
  logic signed [OUT_W-1:0] lut [N];
  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam logic signed [OUT_W-1:0] ENTRY = lut_entry(k);
    assign lut[k] = ENTRY;
  end

  // NOTE: every signal written here gets a value before any branch, so no latches.
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], rf_in};
    sum           = {1'b0, phase_q} + {1'b0, active_inc_q};
    wrap          = sum[PHASE_W];
    phase_d       = phase_clr ? '0 : sum[PHASE_W-1:0];
    state_d       = state_q;
    active_inc_d  = active_inc_q;
    pending_inc_d = pending_inc_q;
    case (state_q)
      ST_IDLE: begin
        if (inc_load) begin
          pending_inc_d = inc_data;
          state_d       = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // Swapping on wrap keeps the phase continuous; a stalled or cleared NCO can swap at once.
        if (wrap || active_inc_q == '0 || phase_clr) begin
          active_inc_d = pending_inc_q;
          state_d      = ST_IDLE;
        end
      end
    endcase
  end

`ifdef RF_MIXER_NCO_IQ_DITHER_EN
  localparam int DITH_W = PHASE_W - LUT_AW;

  if (DITH_W > 15) begin : g_bad_dither
    $error("rf_mixer_nco_iq: dither needs PHASE_W - LUT_AW <= 15");
  end

  logic [14:0]        lfsr_q, lfsr_d;
  logic [PHASE_W-1:0] dither;

  always_comb begin
    lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    dither = PHASE_W'(lfsr_q[DITH_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!RSTb) lfsr_q <= 15'd1;
    else       lfsr_q <= lfsr_d;
  end

  assign addr_cos = LUT_AW'((phase_q + dither) >> DITH_W);
`else
  assign addr_cos = phase_q[PHASE_W-1 -: LUT_AW];
`endif

  always_comb begin
    rf_sync   = sync_q[SYNC_STAGES-1];
    addr_msin = addr_cos + QTR;
    lo_cos    = lut[addr_cos];
    lo_msin   = lut[addr_msin];
    i_out_d   = rf_sync ? -lo_cos  : lo_cos;
    q_out_d   = rf_sync ? -lo_msin : lo_msin;
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!RSTb) begin
      sync_q        <= '0;
      phase_q       <= '0;
      active_inc_q  <= RESET_INC;
      pending_inc_q <= '0;
      state_q       <= ST_IDLE;
      i_out_q       <= '0;
      q_out_q       <= '0;
      lo_i_q        <= '0;
      lo_q_q        <= '0;
      valid_pre_q   <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      phase_q       <= phase_d;
      active_inc_q  <= active_inc_d;
      pending_inc_q <= pending_inc_d;
      state_q       <= state_d;
      i_out_q       <= i_out_d;
      q_out_q       <= q_out_d;
      lo_i_q        <= lo_cos;
      lo_q_q        <= lo_msin;
      valid_pre_q   <= 1'b1;
      out_valid_q   <= valid_pre_q;
    end
  end

  assign rf_out    = sync_q[SYNC_STAGES-1];
  assign inc_busy  = (state_q == ST_PENDING);
  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign lo_i      = lo_i_q;
  assign lo_q      = lo_q_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rf_mixer_nco_iq.sv
// Scoreboard bench for rf_mixer_nco_iq: directed steps push expected I/Q/LO/busy,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_rf_mixer_nco_iq;

  logic                clk = 1'b0;
  logic                RSTb;
  logic                rf_in;
  logic                rf_out;
  logic [15:0]         inc_data;
  logic                inc_load;
  logic                inc_busy;
  logic                phase_clr;
  logic signed [3:0]   i_out, q_out, lo_i, lo_q;
  logic                out_valid;

  rf_mixer_nco_iq #(
    .PHASE_W(16), .LUT_AW(4), .OUT_W(4), .SYNC_STAGES(2), .RESET_INC(16'h1000)
  ) dut (
    .clk(clk), .RSTb(RSTb), .rf_in(rf_in), .rf_out(rf_out),
    .inc_data(inc_data), .inc_load(inc_load), .inc_busy(inc_busy),
    .phase_clr(phase_clr), .i_out(i_out), .q_out(q_out),
    .lo_i(lo_i), .lo_q(lo_q), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // round(7*cos(2*pi*k/16)), worked out by hand
  int COS [16] = '{7, 6, 5, 3, 0, -3, -5, -6, -7, -6, -5, -3, 0, 3, 5, 6};

  typedef struct {
    int   i;
    int   q;
    int   li;
    int   lq;
    logic busy;
  } exp_t;

  exp_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] ph;
  logic [15:0] inc_cur;
  logic        rf_d1, rf_d2;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (out_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("i_out", i_out, e.i);
      check("q_out", q_out, e.q);
      check("lo_i", lo_i, e.li);
      check("lo_q", lo_q, e.lq);
      check("inc_busy", {31'd0, inc_busy}, {31'd0, e.busy});
    end
  end

  // Drive one cycle; expected outputs for the next edge come from the hand-tracked
  // phase and the RF value driven two cycles earlier.
  task automatic step(input logic rf, input logic ld, input logic [15:0] data,
                      input logic clr, input logic busy_after);
    exp_t       e;
    logic [3:0] a;
    logic [3:0] aq;
    rf_in     = rf;
    inc_load  = ld;
    inc_data  = data;
    phase_clr = clr;
    a         = ph[15:12];
    aq        = a + 4'd4;
    e.li      = COS[a];
    e.lq      = COS[aq];
    e.i       = rf_d2 ? -e.li : e.li;
    e.q       = rf_d2 ? -e.lq : e.lq;
    e.busy    = busy_after;
    exp_q.push_back(e);
    rf_d2 = rf_d1;
    rf_d1 = rf;
    ph    = clr ? 16'h0000 : ph + inc_cur;
    @(posedge clk);
    #1;
    inc_load  = 1'b0;
    phase_clr = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    RSTb      = 1'b0;
    rf_in     = 1'b0;
    inc_load  = 1'b0;
    inc_data  = '0;
    phase_clr = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_inc_busy", {31'd0, inc_busy}, 0);
    check("rst_rf_out", {31'd0, rf_out}, 0);
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
    check("rst_lo_i", lo_i, 0);
    check("rst_lo_q", lo_q, 0);
    RSTb = 1'b1;
    @(posedge clk);
    #1;
    check("valid_first_cycle", {31'd0, out_valid}, 0);
    ph      = 16'h1000;
    inc_cur = 16'h1000;
    rf_d1   = 1'b0;
    rf_d2   = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [15:0] rf_pat;
    rf_pat = 16'b1111_0110_0011_1111;

    // Free-running LO with rf=0: full period of the cos table
    do_reset(3);
    for (int k = 0; k < 18; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // rf=1 negates; toggles reach i_out three cycles later
    do_reset(2);
    for (int k = 0; k < 16; k++) step(rf_pat[k], 1'b0, 16'h0, 1'b0, 1'b0);

    // Retune at wrap, loads while busy and on the apply cycle are ignored
    do_reset(2);
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b0);  // 0x1000
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b0);  // 0x2000
    step(1'b0, 1'b1, 16'h2000, 1'b0, 1'b1);  // 0x3000 load
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b1);  // 0x4000
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b1);  // 0x5000
    step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1);  // 0x6000 ignored load
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);  // 0x7000..0xE000
    step(1'b0, 1'b1, 16'h0300, 1'b0, 1'b0);  // 0xF000 wrap applies, load ignored
    inc_cur = 16'h2000;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Load zero at wrap, then a load while active_inc==0 applies at once
    do_reset(2);
    step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);  // 0x1000 load 0
    for (int k = 0; k < 13; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);  // 0x2000..0xE000
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b0);  // 0xF000 apply 0
    inc_cur = 16'h0000;
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b0);  // stalled at 0
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0800, 1'b0, 1'b1);  // load 0x0800
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b0);  // active==0: apply
    inc_cur = 16'h0800;
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // phase_clr at 0x7000 with a pending load applies it immediately
    do_reset(2);
    step(1'b0, 1'b1, 16'h0300, 1'b0, 1'b1);  // 0x1000 load
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);  // 0x2000..0x6000
    step(1'b0, 1'b0, 16'h0,    1'b1, 1'b0);  // 0x7000 clear
    inc_cur = 16'h0300;
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // One-cycle reset mid-PENDING discards the pending increment
    do_reset(2);
    step(1'b0, 1'b1, 16'h2000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0,    1'b0, 1'b1);
    do_reset(1);
    step(1'b0, 1'b0, 16'h0,    1'b1, 1'b0);  // clear in IDLE: no increment swap
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_mixer_nco_iq.md
Name: rf_mixer_nco_iq

Overview:
- Parametrised quadrature successor to the single-channel 1-bit RF downconverter.
- Synchronises the 1-bit RF comparator input, runs a phase accumulator NCO, and looks up a cos/-sin LO.
- Mixes the RF input against the LO to produce signed I and Q IF samples for the CIC/decimation chain.
- Adds glitch-free, phase-continuous retuning through a load/busy handshake, plus a phase clear.

Parameters:
- PHASE_W, 16: phase accumulator and increment width.
- LUT_AW, 4: LUT address bits, taken from the phase MSBs; LUT depth N = 2^LUT_AW. Requires LUT_AW >= 2 and LUT_AW < PHASE_W.
- OUT_W, 4: signed width of the LO and IF outputs.
- SYNC_STAGES, 2: RF input synchroniser depth, minimum 2.
- RESET_INC, 0: active phase increment after reset.

Ports:
- clk  in  1  system clock.
- RSTb  in  1  reset, synchronous, active-low.
- rf_in  in  1  asynchronous 1-bit RF comparator input.
- rf_out  out  1  synchronised RF (last synchroniser stage).
- inc_data  in  PHASE_W  new phase increment.
- inc_load  in  1  single-cycle request to load inc_data.
- inc_busy  out  1  new increment pending; further loads are ignored.
- phase_clr  in  1  clear the phase accumulator.
- i_out  out  OUT_W  signed in-phase IF sample.
- q_out  out  OUT_W  signed quadrature IF sample.
- lo_i  out  OUT_W  signed LO cos, unmixed.
- lo_q  out  OUT_W  signed LO -sin, unmixed.
- out_valid  out  1  outputs carry valid samples.

Behaviour:
- Reset (RSTb=0 at a clk edge):
  - synchroniser flops=0, phase=0, active_inc=RESET_INC, pending_inc=0.
  - state=IDLE, inc_busy=0.
  - i_out=q_out=lo_i=lo_q=0, out_valid=0.
  - Reset mid-operation discards any pending increment.
- Synchroniser: a SYNC_STAGES flop chain, rf_out = last stage.
- Accumulator: every cycle, phase <= phase + active_inc, modulo 2^PHASE_W. wrap = carry out of that addition.
- Increment handshake, two states:
  - IDLE: on inc_load=1, capture pending_inc <= inc_data, go to PENDING, inc_busy=1 from the next cycle.
  - PENDING, leaving when any of these holds:
    - the current cycle's addition has wrap=1;
    - active_inc==0;
    - phase_clr=1.
  - On leaving PENDING: active_inc <= pending_inc, return to IDLE, inc_busy=0 the following cycle.
  - The new increment is first used in the addition one cycle after the apply.
  - inc_load in PENDING is ignored, with no overwrite.
  - inc_load in the same cycle as the apply is ignored.
- phase_clr:
  - phase <= 0, overriding the accumulate.
  - Any pending increment is applied in the same cycle.
- LUT:
  - entry k = round(A*cos(2*pi*k/N)), A = 2^(OUT_W-1)-1, round half away from zero, generated at elaboration.
  - addr = phase[PHASE_W-1 -: LUT_AW].
  - LO I = LUT[addr]; LO Q = LUT[(addr + N/4) mod N] (= -sin).
- Mixer, registered:
  - i_out/q_out = LO value if rf_out==0, else its negation.
  - lo_i/lo_q = unmixed LO values.
  - Entries are bounded by ±A, so negation never overflows.
- Latency:
  - outputs at cycle n+1 reflect phase and rf_out at cycle n.
  - rf_in to i_out: SYNC_STAGES+1 cycles.
  - phase_clr to output showing addr 0: 2 cycles.
- out_valid: 0 in reset; 1 from the second cycle after RSTb rises; stays 1 until the next reset.

Optional Feature:
- Macro: RF_MIXER_NCO_IQ_DITHER_EN.
- Defined:
  - 15-bit Fibonacci LFSR x^15+x^14+1, seed 1 on reset, steps every cycle.
  - Its low (PHASE_W-LUT_AW) bits are added, mod 2^PHASE_W, to phase before address extraction. This trades spurs for a noise floor.
  - Requires PHASE_W-LUT_AW <= 15.
  - The accumulator itself is unaffected.
- Undefined: plain truncation; no LFSR logic is present.

Test Plan:
- Defaults, RESET_INC=0x1000, rf_in=0, after valid → i_out cycles 7,6,5,3,0,-3,-5,-6,-7,-6,-5,-3,0,3,5,6 (period 16). q_out leads by 4 entries: 0,-3,-5,-6,... lo_i equals i_out.
- Same setup, rf_in=1 held → i_out/q_out exactly negated (-7,-6,...). rf_in toggle appears at i_out 3 cycles later.
- inc=0x1000, phase=0x3000, inc_load with 0x2000 → inc_busy=1 next cycle. The increment stays 0x1000 until phase 0xF000→0x0000 (wrap). Thereafter phase advances 0x2000/cycle. inc_busy falls the cycle after the apply.
- While busy, inc_load with 0x0100 → ignored. After the apply, active_inc is the first value.
- RESET_INC=0, inc_load 0x0800 → applied immediately (active=0 case). Separately, phase_clr at phase 0x7000 with a pending load → phase 0 next cycle, new increment used from then. i_out=7 two cycles after phase_clr.
- RSTb low for one cycle mid-PENDING → inc_busy=0, all outputs 0, out_valid 0, active_inc=RESET_INC, pending discarded.
